// File: rtl/demux18_pkg.sv
// Shared constants and types for the demux18_seq 1-to-8 registered distributor.

package demux18_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned SEL_W     = 3;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {
    ADDR,
    RR
  } state_t;

endpackage

// File: rtl/demux18_seq_dec38_en.sv
// Combinational 3-to-8 one-hot decoder with enable; drives lane write enables and strobes.

module dec38_en
  import demux18_pkg::*;
(
  input  logic                 en_i,
  input  logic [SEL_W-1:0]     sel_i,
  output logic [NUM_LANES-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      // An unknown select falls to the default so no lane is enabled.
      case (sel_i)
        3'd0:    dec_o = 8'b0000_0001;
        3'd1:    dec_o = 8'b0000_0010;
        3'd2:    dec_o = 8'b0000_0100;
        3'd3:    dec_o = 8'b0000_1000;
        3'd4:    dec_o = 8'b0001_0000;
        3'd5:    dec_o = 8'b0010_0000;
        3'd6:    dec_o = 8'b0100_0000;
        3'd7:    dec_o = 8'b1000_0000;
        default: dec_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/demux18_seq.sv
// Registered 1-to-8 distributor with addressed and round-robin modes.
// Optional build macro DEMUX18_CLEAR_EN zeroes non-selected lanes on addressed writes.

module demux18_seq
  import demux18_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DW-1:0]           DIN,
  input  logic                    DIN_VLD,
  input  logic [SEL_W-1:0]        SEL,
  input  logic                    MODE,
  output logic [NUM_LANES*DW-1:0] OUT,
  output logic [NUM_LANES-1:0]    OUT_STB,
  output logic                    FRAME_VLD,
  output logic [SEL_W-1:0]        PTR
);

  state_t                           state_q, state_d;
  logic [SEL_W-1:0]                 ptr_q, ptr_d;
  logic [NUM_LANES-1:0][DW-1:0]     lanes_q, lanes_d;
  logic [NUM_LANES-1:0]             stb_q, stb_d;
  logic                             frame_q, frame_d;

  logic                             mode_switch;
  logic [SEL_W-1:0]                 ptr_base;
  logic                             rr_wr;
  logic [SEL_W-1:0]                 wr_idx;
  logic [NUM_LANES-1:0]             wr_en;

  // State register and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ADDR;
      ptr_q   <= '0;
      lanes_q <= '0;
      stb_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lanes_q <= lanes_d;
      stb_q   <= stb_d;
      frame_q <= frame_d;
    end
  end

  // Next-state: the state simply follows MODE at every edge.
  always_comb begin
    state_d = state_q;
    unique case (MODE)
      MODE_ADDR: state_d = ADDR;
      MODE_RR:   state_d = RR;
      default:   state_d = state_q;
    endcase
  end

  // Write selection: a write in a transition cycle uses the new mode with a fresh pointer.
  always_comb begin
    mode_switch = (state_d != state_q);
    ptr_base    = mode_switch ? '0 : ptr_q;
    rr_wr       = DIN_VLD && (state_d == RR);
    wr_idx      = rr_wr ? ptr_base : SEL;
  end

  dec38_en u_dec (
    .en_i  (DIN_VLD),
    .sel_i (wr_idx),
    .dec_o (wr_en)
  );

  // Lane, strobe, frame and pointer next values.
  always_comb begin
    lanes_d = lanes_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wr_en[k]) begin
        lanes_d[k] = DIN;
      end
`ifdef DEMUX18_CLEAR_EN
      else if ((state_d == ADDR) && (|wr_en)) begin
        lanes_d[k] = '0;
      end
`endif
    end
    stb_d   = wr_en;
    frame_d = rr_wr && (ptr_base == 3'd7);
    ptr_d   = rr_wr ? (ptr_base + 3'd1) : ptr_base;
  end

  assign OUT       = lanes_q;
  assign OUT_STB   = stb_q;
  assign FRAME_VLD = frame_q;
  assign PTR       = ptr_q;

endmodule

// File: tb/tb_demux18_seq.sv
// Directed self-checking bench for demux18_seq with DW = 1.

module tb_demux18_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic [0:0] DIN;
  logic       DIN_VLD;
  logic [2:0] SEL;
  logic       MODE;
  logic [7:0] OUT;
  logic [7:0] OUT_STB;
  logic       FRAME_VLD;
  logic [2:0] PTR;

  int n_assert = 0;
  int n_fail   = 0;

  demux18_seq #(.DW(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VLD   (DIN_VLD),
    .SEL       (SEL),
    .MODE      (MODE),
    .OUT       (OUT),
    .OUT_STB   (OUT_STB),
    .FRAME_VLD (FRAME_VLD),
    .PTR       (PTR)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input logic rst, input logic vld, input logic din,
                     input logic [2:0] sel, input logic mode);
    RST     = rst;
    DIN_VLD = vld;
    DIN     = din;
    SEL     = sel;
    MODE    = mode;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] frame_bits;
  logic [7:0] exp_out;
  int         fv_count;

  initial begin
    frame_bits = 8'h4D;  // lane k gets bit k: 1,0,1,1,0,0,1,0

    // Reset held two cycles with a write pending.
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
    chk("rst_out", OUT, 8'h00);
    chk("rst_stb", OUT_STB, 8'h00);
    chk("rst_fv", FRAME_VLD, 1'b0);
    chk("rst_ptr", PTR, 3'd0);

    // Addressed writes.
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
    chk("addr5_out", OUT, 8'h20);
    chk("addr5_stb", OUT_STB, 8'h20);
    chk("addr5_ptr", PTR, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
`ifdef DEMUX18_CLEAR_EN
    exp_out = 8'h04;
`else
    exp_out = 8'h24;
`endif
    chk("addr2_out", OUT, exp_out);
    chk("addr2_stb", OUT_STB, 8'h04);
    cyc(1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
    chk("idle_stb", OUT_STB, 8'h00);
    chk("idle_out", OUT, exp_out);

    // Back-to-back round-robin frame; first write is also the mode-switch cycle.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, frame_bits[k], 3'd0, 1'b1);
      chk("rr_stb", OUT_STB, 8'h01 << k);
      chk("rr_ptr", PTR, (k + 1) % 8);
      chk("rr_fv", FRAME_VLD, (k == 7) ? 1'b1 : 1'b0);
    end
    chk("rr_out", OUT, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("rr_fv_after", FRAME_VLD, 1'b0);
    chk("rr_stb_after", OUT_STB, 8'h00);

    // Reset between frames, then a gapped frame.
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("rst2_out", OUT, 8'h00);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, frame_bits[k], 3'd0, 1'b1);
      chk("gap_stb", OUT_STB, 8'h01 << k);
      chk("gap_fv", FRAME_VLD, (k == 7) ? 1'b1 : 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
      chk("gap_stb_idle", OUT_STB, 8'h00);
      chk("gap_fv_idle", FRAME_VLD, 1'b0);
      chk("gap_ptr_hold", PTR, (k + 1) % 8);
    end
    chk("gap_out", OUT, 8'h4D);

    // Mode switch mid-frame: 3 zero words into lanes 0..2.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("ms_ptr3", PTR, 3'd3);
    chk("ms_out", OUT, 8'h48);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ms_ptr_clr", PTR, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    chk("ms_lane0_stb", OUT_STB, 8'h01);
    chk("ms_lane0_out", OUT, 8'h49);
    chk("ms_ptr1", PTR, 3'd1);

    // Reset mid-frame: 4 more words (5 in this frame), then reset with a write pending.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    chk("rmf_ptr5", PTR, 3'd5);
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
    chk("rmf_out", OUT, 8'h00);
    chk("rmf_ptr", PTR, 3'd0);
    chk("rmf_fv", FRAME_VLD, 1'b0);
    fv_count = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
      if (FRAME_VLD === 1'b1) fv_count++;
    end
    chk("rmf_fv_last", FRAME_VLD, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    if (FRAME_VLD === 1'b1) fv_count++;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    if (FRAME_VLD === 1'b1) fv_count++;
    chk("rmf_fv_count", fv_count, 1);
    chk("rmf_out_full", OUT, 8'hFF);
    chk("rmf_ptr_wrap", PTR, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
